// File: rtl/compositor_pkg.sv
// Shared types and constants for the pixel compositor.
// Colour is carried as a packed {R,G,B} struct throughout.
package compositor_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      NORMAL,
      FLASH_ON,
      FLASH_OFF
   } flash_state_t;

   localparam logic [23:0] BLACK   = 24'h000000;
   localparam logic [7:0]  FLASH_R = 8'hFF;

   // Red hit tint: saturate red, dim green and blue to a quarter.
   function automatic rgb_t flash_tint(input rgb_t c);
      rgb_t t;
      t.r = FLASH_R;
      t.g = c.g >> 2;
      t.b = c.b >> 2;
      return t;
   endfunction

   // Scanline darkening: halve every channel.
   function automatic rgb_t halve(input rgb_t c);
      rgb_t t;
      t.r = c.r >> 1;
      t.g = c.g >> 1;
      t.b = c.b >> 1;
      return t;
   endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register used to align sprite sideband data
// with the registered background RAM read.
module pixel_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] delayed
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one stage per clock; reset flushes every stage to zero.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= data;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Layer merge, hit-flash effect and output register for the VGA path.
// Optional scanline darkening is built when SCANLINE_EN is defined.
module pixel_compositor
   import compositor_pkg::*;
#(
   parameter int BG_LAT       = 1,
   parameter int FLASH_FRAMES = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        display_en,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        bg_on,
   input  logic [7:0]  bg_R,
   input  logic [7:0]  bg_G,
   input  logic [7:0]  bg_B,
   input  logic        bullet_on,
   input  logic        player_on,
   input  logic        enemy_on,
   input  logic [23:0] bullet_rgb,
   input  logic [23:0] player_rgb,
   input  logic [23:0] enemy_rgb,
   input  logic        player_hit,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        flash_active
);

   localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

   typedef struct packed {
`ifdef SCANLINE_EN
      logic row_odd;
`endif
      logic en;
      logic bullet_hit;
      logic player_on;
      logic enemy_hit;
      rgb_t bullet;
      rgb_t player;
      rgb_t enemy;
   } side_t;

   side_t        side_now;
   side_t        side_dly;
   rgb_t         merged;
   flash_state_t state;
   logic [7:0]   count;
   logic [2:0]   fsync;
   logic         frame_tick;
   logic         unused_bits;

`ifdef SCANLINE_EN
   assign side_now.row_odd = DrawY[0];
   assign unused_bits      = ^{DrawX, DrawY[9:1]};
`else
   assign unused_bits      = ^{DrawX, DrawY};
`endif
   assign side_now.en         = display_en;
   assign side_now.bullet_hit = bullet_on;
   assign side_now.player_on  = player_on;
   assign side_now.enemy_hit  = enemy_on;
   assign side_now.bullet     = bullet_rgb;
   assign side_now.player     = player_rgb;
   assign side_now.enemy      = enemy_rgb;

   pixel_delay_line #(
      .WIDTH($bits(side_t)),
      .DEPTH(BG_LAT)
   ) u_align (
      .Clk    (Clk),
      .Reset  (Reset),
      .data   (side_now),
      .delayed(side_dly)
   );

   // Two-flop synchroniser plus a third flop for edge detect.
   always_ff @(posedge Clk) begin
      if (Reset) fsync <= 3'b000;
      else       fsync <= {fsync[1:0], frame_clk};
   end

   assign frame_tick = fsync[1] & ~fsync[2];

   // Flash FSM: hit reloads and forces FLASH_ON, ticks toggle and count down.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= NORMAL;
         count        <= '0;
         flash_active <= 1'b0;
      end else if (player_hit) begin
         state        <= FLASH_ON;
         count        <= FLASH_LOAD;
         flash_active <= 1'b1;
      end else if (frame_tick && state != NORMAL) begin
         count <= count - 8'd1;
         if (count == 8'd1) begin
            state        <= NORMAL;
            flash_active <= 1'b0;
         end else if (state == FLASH_ON) begin
            state <= FLASH_OFF;
         end else begin
            state <= FLASH_ON;
         end
      end
   end

   // Merge stage: fixed layer priority, blanking, flash tint, scanlines.
   always_comb begin
      merged = BLACK;
      if (side_dly.en) begin
         if (side_dly.bullet_hit)     merged = side_dly.bullet;
         else if (side_dly.player_on) merged = side_dly.player;
         else if (side_dly.enemy_hit) merged = side_dly.enemy;
         else if (bg_on)              merged = {bg_R, bg_G, bg_B};
         if (state == FLASH_ON)       merged = flash_tint(merged);
`ifdef SCANLINE_EN
         if (side_dly.row_odd)        merged = halve(merged);
`endif
      end
   end

   // Registered colour output towards the VGA controller.
   always_ff @(posedge Clk) begin
      if (Reset) {Red, Green, Blue} <= BLACK;
      else       {Red, Green, Blue} <= merged;
   end

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: vector table, directed
// latency/flash sequences and randomized traffic against a model.
module tb_pixel_compositor;

   localparam int LAT = 1;
   localparam int NFR = 2;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic        display_en = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        bg_on = 1'b0;
   logic [7:0]  bg_R = '0;
   logic [7:0]  bg_G = '0;
   logic [7:0]  bg_B = '0;
   logic        bullet_on = 1'b0;
   logic        player_on = 1'b0;
   logic        enemy_on = 1'b0;
   logic [23:0] bullet_rgb = '0;
   logic [23:0] player_rgb = '0;
   logic [23:0] enemy_rgb = '0;
   logic        player_hit = 1'b0;
   logic [7:0]  Red;
   logic [7:0]  Green;
   logic [7:0]  Blue;
   logic        flash_active;

   always #5 Clk = ~Clk;

   pixel_compositor #(
      .BG_LAT(LAT),
      .FLASH_FRAMES(NFR)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .display_en(display_en), .DrawX(DrawX), .DrawY(DrawY),
      .bg_on(bg_on), .bg_R(bg_R), .bg_G(bg_G), .bg_B(bg_B),
      .bullet_on(bullet_on), .player_on(player_on), .enemy_on(enemy_on),
      .bullet_rgb(bullet_rgb), .player_rgb(player_rgb),
      .enemy_rgb(enemy_rgb), .player_hit(player_hit),
      .Red(Red), .Green(Green), .Blue(Blue),
      .flash_active(flash_active)
   );

   int total = 0;
   int bad = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        en;
      logic        y0;
      logic        bo;
      logic        po;
      logic        eo;
      logic [23:0] bc;
      logic [23:0] pc;
      logic [23:0] ec;
   } pix_t;

   pix_t        hist[$];
   int          rem = 0;
   bit          phase = 0;
   bit          p1 = 0, p2 = 0, p3 = 0;
   logic [23:0] exp_rgb = '0;
   logic        exp_fa = 1'b0;

   function automatic logic [23:0] compose(pix_t s, logic bgo,
                                           logic [23:0] bg, bit fl);
      logic [23:0] c;
      if (!s.en) return 24'h0;
      if (s.bo)      c = s.bc;
      else if (s.po) c = s.pc;
      else if (s.eo) c = s.ec;
      else if (bgo)  c = bg;
      else           c = 24'h0;
      if (fl) c = {8'hFF, 8'(c[15:8] / 4), 8'(c[7:0] / 4)};
`ifdef SCANLINE_EN
      if (s.y0) c = {8'(c[23:16] / 2), 8'(c[15:8] / 2), 8'(c[7:0] / 2)};
`endif
      return c;
   endfunction

   task automatic model_edge();
      pix_t cur;
      pix_t old;
      bit   tick;
      cur = '{en: display_en, y0: DrawY[0], bo: bullet_on,
              po: player_on, eo: enemy_on, bc: bullet_rgb,
              pc: player_rgb, ec: enemy_rgb};
      if (Reset) begin
         exp_rgb = 24'h0;
         exp_fa  = 1'b0;
         rem     = 0;
         phase   = 0;
         p1 = 0; p2 = 0; p3 = 0;
         hist.delete();
         for (int i = 0; i < LAT; i++) hist.push_back('0);
      end else begin
         tick = p2 && !p3;
         p3 = p2; p2 = p1; p1 = frame_clk;
         old = hist.pop_front();
         hist.push_back(cur);
         exp_rgb = compose(old, bg_on, {bg_R, bg_G, bg_B},
                           (rem > 0) && phase);
         if (player_hit) begin
            rem   = NFR;
            phase = 1;
         end else if (tick && rem > 0) begin
            rem   = rem - 1;
            phase = !phase;
         end
         exp_fa = (rem > 0);
      end
   endtask

   // One clock: model follows the edge, outputs compared mid-cycle.
   task automatic step();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      DrawX = DrawX + 10'd1;
      total++;
      if ({Red, Green, Blue} !== exp_rgb) begin
         bad++;
         $display("FAIL model_rgb t=%0t got %h want %h",
                  $time, {Red, Green, Blue}, exp_rgb);
      end
      total++;
      if (flash_active !== exp_fa) begin
         bad++;
         $display("FAIL model_flash t=%0t got %b want %b",
                  $time, flash_active, exp_fa);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic set_layers(input logic en, input logic bo,
                             input logic po, input logic eo,
                             input logic [23:0] bc, input logic [23:0] pc,
                             input logic [23:0] ec, input logic bgo,
                             input logic [23:0] bg);
      display_en = en;
      bullet_on  = bo;
      player_on  = po;
      enemy_on   = eo;
      bullet_rgb = bc;
      player_rgb = pc;
      enemy_rgb  = ec;
      bg_on      = bgo;
      {bg_R, bg_G, bg_B} = bg;
   endtask

   // frame_clk rising edge; optional hit lands on the resulting tick.
   task automatic frame_pulse(input bit hit);
      frame_clk = 1'b1;
      step();
      step();
      player_hit = hit;
      step();
      player_hit = 1'b0;
      frame_clk = 1'b0;
      step();
      step();
      step();
   endtask

   typedef struct {
      logic        en, bo, po, eo, bgo;
      logic [23:0] bc, pc, ec, bg, want;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1, 1, 1, 1, 1, 24'h112233, 24'h445566, 24'h778899,
                  24'hAABBCC, 24'h112233};
      vecs[1] = '{1, 0, 1, 1, 1, 24'h112233, 24'h445566, 24'h778899,
                  24'hAABBCC, 24'h445566};
      vecs[2] = '{1, 0, 0, 1, 1, 24'h112233, 24'h445566, 24'h778899,
                  24'hAABBCC, 24'h778899};
      vecs[3] = '{1, 0, 0, 0, 1, 24'h112233, 24'h445566, 24'h778899,
                  24'h4080C0, 24'h4080C0};
      vecs[4] = '{1, 0, 0, 0, 0, 24'h112233, 24'h445566, 24'h778899,
                  24'h4080C0, 24'h000000};
      vecs[5] = '{0, 1, 1, 1, 1, 24'h112233, 24'h445566, 24'h778899,
                  24'hAABBCC, 24'h000000};
      vecs[6] = '{1, 1, 0, 0, 1, 24'hFEDCBA, 24'h445566, 24'h778899,
                  24'hAABBCC, 24'hFEDCBA};
      vecs[7] = '{1, 0, 1, 0, 0, 24'h112233, 24'h0000FF, 24'h778899,
                  24'hAABBCC, 24'h0000FF};

      for (int i = 0; i < LAT; i++) hist.push_back('0);

      // Reset with every layer driven.
      Reset = 1'b1;
      set_layers(1, 1, 1, 1, 24'h112233, 24'h445566, 24'h778899,
                 1, 24'hAABBCC);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
         chk("reset_flash", {31'h0, flash_active}, 32'h0);
      end
      Reset = 1'b0;

      // Priority / blanking table.
      for (int i = 0; i < 8; i++) begin
         set_layers(vecs[i].en, vecs[i].bo, vecs[i].po, vecs[i].eo,
                    vecs[i].bc, vecs[i].pc, vecs[i].ec,
                    vecs[i].bgo, vecs[i].bg);
         for (int k = 0; k < LAT + 1; k++) step();
         total++;
         if ({Red, Green, Blue} !== vecs[i].want) begin
            bad++;
            $display("FAIL table[%0d]: got %h want %h",
                     i, {Red, Green, Blue}, vecs[i].want);
         end
      end

      // Latency: single enemy pixel, background one cycle later.
      set_layers(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      set_layers(1, 0, 0, 1, 0, 0, 24'h00FF00, 0, 0);
      step();
      chk("lat_early", {8'h0, Red, Green, Blue}, 32'h0);
      set_layers(1, 0, 0, 0, 0, 0, 0, 1, 24'h102030);
      step();
      chk("lat_enemy", {8'h0, Red, Green, Blue}, 32'h00FF00);
      set_layers(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("lat_after", {8'h0, Red, Green, Blue}, 32'h0);

      // Flash sequence on a plain background.
      set_layers(1, 0, 0, 0, 0, 0, 0, 1, 24'h4080C0);
      repeat (2) step();
      chk("bg_plain", {8'h0, Red, Green, Blue}, 32'h4080C0);
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      chk("hit_flag", {31'h0, flash_active}, 32'h1);
      chk("hit_same_px", {8'h0, Red, Green, Blue}, 32'h4080C0);
      step();
      chk("flash_on_px", {8'h0, Red, Green, Blue}, 32'hFF2030);
      frame_pulse(0);
      chk("flash_off_px", {8'h0, Red, Green, Blue}, 32'h4080C0);
      chk("flash_off_flag", {31'h0, flash_active}, 32'h1);
      frame_pulse(0);
      chk("flash_end_flag", {31'h0, flash_active}, 32'h0);
      chk("flash_end_px", {8'h0, Red, Green, Blue}, 32'h4080C0);

      // Hit coincident with a frame tick mid-flash.
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      step();
      chk("re_on_px", {8'h0, Red, Green, Blue}, 32'hFF2030);
      frame_pulse(0);
      chk("re_off_px", {8'h0, Red, Green, Blue}, 32'h4080C0);
      frame_pulse(1);
      chk("coinc_px", {8'h0, Red, Green, Blue}, 32'hFF2030);
      chk("coinc_flag", {31'h0, flash_active}, 32'h1);
      frame_pulse(0);
      chk("reload_flag", {31'h0, flash_active}, 32'h1);
      chk("reload_px", {8'h0, Red, Green, Blue}, 32'h4080C0);
      frame_pulse(0);
      chk("reload_end", {31'h0, flash_active}, 32'h0);

      // Reset while flashing.
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      step();
      chk("pre_rst_px", {8'h0, Red, Green, Blue}, 32'hFF2030);
      Reset = 1'b1;
      step();
      chk("mid_rst_px", {8'h0, Red, Green, Blue}, 32'h0);
      chk("mid_rst_flag", {31'h0, flash_active}, 32'h0);
      Reset = 1'b0;
      step();
      chk("post_rst_px", {8'h0, Red, Green, Blue}, 32'h0);
      step();
      chk("post_rst_bg", {8'h0, Red, Green, Blue}, 32'h4080C0);

`ifdef SCANLINE_EN
      DrawY = 10'd1;
      repeat (2) step();
      chk("scanline", {8'h0, Red, Green, Blue}, 32'h204060);
      DrawY = 10'd0;
`endif

      // Randomized traffic checked by the model inside step().
      for (int n = 0; n < 600; n++) begin
         Reset      = ($urandom_range(0, 99) == 0);
         display_en = ($urandom_range(0, 7) != 0);
         bullet_on  = ($urandom_range(0, 5) == 0);
         player_on  = ($urandom_range(0, 4) == 0);
         enemy_on   = ($urandom_range(0, 3) == 0);
         bg_on      = ($urandom_range(0, 3) != 0);
         bullet_rgb = 24'($urandom);
         player_rgb = 24'($urandom);
         enemy_rgb  = 24'($urandom);
         {bg_R, bg_G, bg_B} = 24'($urandom);
         DrawY      = 10'($urandom);
         player_hit = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
         step();
      end
      Reset = 1'b0;
      player_hit = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Downstream consumer of the background layer. Merges background RGB with the bullet, player and enemy sprite layers by fixed priority and drives final VGA RGB.
- Delay-aligns the combinational sprite layers to the registered background RAM read.
- Applies a frame-counted red "hit flash" effect. Sits between the layer generators and the VGA controller colour inputs.

Parameters:
BG_LAT, 1, background RAM read latency in Clk cycles (legal 1..4)
FLASH_FRAMES, 8, number of frame_clk rising edges a hit flash lasts (legal 1..255)

Ports:
Clk  in  1  system pixel clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  vsync-rate frame tick, asynchronous to Clk
display_en  in  1  high while DrawX/DrawY are in the visible region
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
bg_on  in  1  background pixel valid, arrives BG_LAT cycles after DrawX
bg_R, bg_G, bg_B  in  8 each  background colour, aligned with bg_on
bullet_on, player_on, enemy_on  in  1 each  sprite layer hits, same cycle as DrawX
bullet_rgb, player_rgb, enemy_rgb  in  24 each  sprite colours {R,G,B}, same cycle as DrawX
player_hit  in  1  single-cycle pulse, player was struck
Red, Green, Blue  out  8 each  final pixel colour
flash_active  out  1  high while the flash FSM is not NORMAL

Behaviour:
- Reset: Red/Green/Blue=0, flash_active=0, FSM=NORMAL, frame counter=0, all delay stages cleared.
- Alignment:
  - display_en, DrawY[0], the three *_on bits and the three sprite colours pass through a BG_LAT-deep delay line.
  - Stage BG_LAT merges them with bg_*.
  - Output is registered, so total latency from DrawX to Red/Green/Blue is BG_LAT+1 cycles.
- Priority, at the merge stage: bullet > player > enemy > background (bg_on) > black 0x000000.
- Blanking: if delayed display_en=0, output 0 regardless of any layer.
- Frame tick: frame_clk goes through a 2-flop synchroniser plus rising-edge detect, giving a 1-cycle frame_tick.
- FSM states: NORMAL, FLASH_ON, FLASH_OFF.
  - NORMAL -> FLASH_ON on player_hit; load count=FLASH_FRAMES.
  - FLASH_ON <-> FLASH_OFF toggle on each frame_tick, and count decrements on each frame_tick.
  - When count reaches 0 on a frame_tick, go to NORMAL.
  - player_hit while flashing reloads count=FLASH_FRAMES and forces FLASH_ON.
  - player_hit coincident with frame_tick: the reload wins.
- Flash colour: in FLASH_ON, every visible merged pixel becomes {8'hFF, G>>2, B>>2}. FLASH_OFF and NORMAL leave the colour unchanged.
- flash_active = (state != NORMAL), registered.
- The FSM state is sampled at the merge stage, so a mode change takes effect on the next merged pixel.
- Reset mid-flash: NORMAL immediately, with outputs 0 on the next cycle.

Optional Feature:
- Macro SCANLINE_EN.
- When defined: after the flash stage, pixels whose delayed DrawY[0]=1 have each channel halved (logical shift right by 1). Latency is unchanged.
- When undefined: the DrawY[0] delay path is not instantiated and no darkening is applied.

Decomposition:
- compositor_pkg holds:
  - rgb_t (packed struct of R, G, B, 8 bits each)
  - flash_state_t enum {NORMAL, FLASH_ON, FLASH_OFF}
  - constant BLACK = 24'h000000
  - constant FLASH_R = 8'hFF
- One sub-module, pixel_delay_line: parameterised width and depth; synchronous reset clears it to 0. Instantiated once for the aligned sideband bundle.

Test Plan:
- Reset held 3 cycles with all layers on -> Red/Green/Blue=0, flash_active=0.
- BG_LAT=1, display_en=1, enemy_on=1 enemy_rgb=0x00FF00, bg_on=1 bg=0x102030 one cycle later -> output 0x00FF00 exactly 2 cycles after enemy_on.
- bullet_on=player_on=enemy_on=1 with distinct colours -> bullet colour out. With display_en=0 -> 0x000000.
- Only bg_on=1 with 0x4080C0, then player_hit pulse -> flash_active=1 next cycle, output 0xFF2030 during FLASH_ON.
- Further sequence:
  - FLASH_FRAMES=2: after 1 frame_tick the output is 0x4080C0 (FLASH_OFF).
  - After the 2nd frame_tick, flash_active=0.
- player_hit coincident with frame_tick mid-flash -> FSM=FLASH_ON, count reloaded. SCANLINE_EN build: odd row with bg 0x4080C0 -> 0x204060.
